// File: rtl/risc16_pkg.sv
// ---------------------------------------------------------------------------
// risc16_pkg
//
// Shared definitions for the 16-bit RISC multi-cycle control path.
//   - opcode constants (instr[15:12])
//   - controller state encoding
//   - decoded instruction classes produced by opcode_decoder
//   - ALU function codes driven onto alu_op
//   - trap cause codes reported on trap_cause
//   - small class helpers used by the controller's output decode
// ---------------------------------------------------------------------------
package risc16_pkg;

    // Opcode field values; anything not listed here is illegal.
    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_RTYPE = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_J     = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // ALU function codes the controller itself picks (R-type passes funct).
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Controller states.
    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        TRAP
    } state_t;

    // Instruction classes, one per legal opcode.
    typedef enum logic [2:0] {
        CLS_LW,
        CLS_SW,
        CLS_RTYPE,
        CLS_ADDI,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_HALT
    } instr_class_t;

    // Reasons for entering TRAP.
    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'b00,
        CAUSE_ILLEGAL      = 2'b01,
        CAUSE_IMEM_TIMEOUT = 2'b10,
        CAUSE_DMEM_TIMEOUT = 2'b11
    } trap_cause_t;

    // Conditional branches (BEQ/BNE) compare with a subtract in EXEC.
    function automatic logic is_cond_branch(input instr_class_t cls);
        return (cls == CLS_BEQ) || (cls == CLS_BNE);
    endfunction

    // Instructions whose second ALU operand is the extended immediate.
    function automatic logic uses_immediate(input instr_class_t cls);
        return (cls == CLS_LW) || (cls == CLS_SW) || (cls == CLS_ADDI);
    endfunction

    // Instructions that finish in EXEC and never touch MEM or WB.
    function automatic logic retires_in_exec(input instr_class_t cls);
        return (cls == CLS_BEQ) || (cls == CLS_BNE) || (cls == CLS_J);
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// ---------------------------------------------------------------------------
// opcode_decoder
//
// Purely combinational map from the 4-bit opcode to an instruction class
// plus a legal flag. The class output is only meaningful when legal = 1.
//
// Ports:
//   opcode  in  4   instr[15:12]
//   cls     out 3   decoded instruction class (instr_class_t)
//   legal   out 1   1 when opcode is one of the defined encodings
// ---------------------------------------------------------------------------
module opcode_decoder
    import risc16_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_t cls,
    output logic         legal
);

    // Table lookup; undefined encodings drop legal and leave cls at a
    // harmless default so the controller can route them straight to TRAP.
    always_comb begin
        cls   = CLS_LW;
        legal = 1'b1;
        case (opcode)
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_RTYPE: cls = CLS_RTYPE;
            OP_ADDI:  cls = CLS_ADDI;
            OP_BEQ:   cls = CLS_BEQ;
            OP_BNE:   cls = CLS_BNE;
            OP_J:     cls = CLS_J;
            OP_HALT:  cls = CLS_HALT;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle control FSM for the 16-bit RISC datapath. Walks each
// instruction through FETCH / DECODE / EXEC / MEM / WB, drives every
// datapath select and enable, waits on the memory ready handshakes with a
// bounded timeout, and parks in TRAP (illegal opcode or timeout) or HALT.
//
// Parameters:
//   TIMEOUT  cycles a memory request may wait before trapping
//   CNT_W    wait counter width, must be able to hold TIMEOUT
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   instr       in  16  IR contents, opcode in [15:12], funct in [2:0]
//   alu_zero    in   1  ALU zero flag, meaningful in EXEC
//   imem_ready  in   1  instruction fetch complete
//   dmem_ready  in   1  data access complete
//   imem_req    out  1  instruction fetch request
//   dmem_req    out  1  data access request
//   ir_write    out  1  load IR
//   pc_write    out  1  load PC from the pc_next mux
//   jump        out  1  pc_next selects the jump target
//   branch      out  1  pc_2bne selects the branch target
//   reg_dst     out  1  1 = instr[5:3], 0 = instr[8:6]
//   alu_src     out  1  1 = extended immediate
//   alu_op      out  3  ALU function
//   mem_read    out  1  data read
//   mem_write   out  1  data write
//   mem_to_reg  out  1  writeback from memory
//   reg_write   out  1  register file write enable
//   retire      out  1  one-cycle pulse per completed instruction
//   trap        out  1  sticky error flag
//   trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import risc16_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        alu_zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        jump,
    output logic        branch,
    output logic        reg_dst,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    state_t       state;
    state_t       next_state;
    trap_cause_t  enter_cause;

    instr_class_t dec_cls;
    logic         dec_legal;
    instr_class_t op_cls;
    instr_class_t cls_eff;

    logic [2:0]   funct_q;
    logic [2:0]   funct_eff;
    logic [2:0]   exec_alu_op;

    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;
    logic             counting;

    logic         retire_q;
    logic         branch_ne;

    logic         unused_instr_bits;

    assign unused_instr_bits = ^instr[11:3];

    opcode_decoder u_decoder (
        .opcode (instr[15:12]),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    // The outputs for the state being entered are registered on the same
    // edge that latches the opcode, so while in DECODE the class and funct
    // must come straight from the decoder; everywhere else the latched copy
    // is the authority.
    always_comb begin
        cls_eff   = op_cls;
        funct_eff = funct_q;
        if (state == DECODE) begin
            cls_eff   = dec_cls;
            funct_eff = instr[2:0];
        end
    end

    // ALU function used during EXEC: R-type passes funct through, the
    // conditional branches compare by subtracting, everything else adds
    // (address generation for LW/SW, ADDI, and a don't-care add for J).
    always_comb begin
        exec_alu_op = ALU_ADD;
        case (cls_eff)
            CLS_RTYPE:        exec_alu_op = funct_eff;
            CLS_BEQ, CLS_BNE: exec_alu_op = ALU_SUB;
            default:          exec_alu_op = ALU_ADD;
        endcase
    end

    // The wait counter only runs while a memory request is actually out.
    // The FETCH cycle straight after reset has imem_req low, so it neither
    // accepts a ready nor counts toward the timeout.
    assign counting     = (state == FETCH && imem_req) || (state == MEM);
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT));

    // Next-state selection. Ready always wins over the timeout check in the
    // same cycle. HALT and TRAP are absorbing; only rst_n leaves them.
    always_comb begin
        next_state  = state;
        enter_cause = CAUSE_NONE;
        case (state)
            FETCH: begin
                if (imem_req) begin
                    if (imem_ready) begin
                        next_state = DECODE;
                    end else if (wait_expired) begin
                        next_state  = TRAP;
                        enter_cause = CAUSE_IMEM_TIMEOUT;
                    end
                end
            end
            DECODE: begin
                if (!dec_legal) begin
                    next_state  = TRAP;
                    enter_cause = CAUSE_ILLEGAL;
                end else if (dec_cls == CLS_HALT) begin
                    next_state = HALT;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                case (op_cls)
                    CLS_LW, CLS_SW:      next_state = MEM;
                    CLS_RTYPE, CLS_ADDI: next_state = WB;
                    default:             next_state = FETCH;
                endcase
            end
            MEM: begin
                if (dmem_ready) begin
                    next_state = (op_cls == CLS_SW) ? FETCH : WB;
                end else if (wait_expired) begin
                    next_state  = TRAP;
                    enter_cause = CAUSE_DMEM_TIMEOUT;
                end
            end
            WB: begin
                next_state = FETCH;
            end
            default: begin
                next_state = state;
            end
        endcase
    end

    // Main sequential block: state, wait counter, latched opcode, and the
    // registered Moore outputs for whichever state is being entered. Since
    // every output flop resets asynchronously, asserting rst_n mid-
    // instruction drops all requests and enables at once and nothing
    // retires. imem_req first rises on the edge after rst_n releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            op_cls     <= CLS_LW;
            funct_q    <= 3'b000;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            jump       <= 1'b0;
            branch     <= 1'b0;
            branch_ne  <= 1'b0;
            reg_dst    <= 1'b0;
            alu_src    <= 1'b0;
            alu_op     <= ALU_ADD;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            reg_write  <= 1'b0;
            retire_q   <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            state <= next_state;

            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (counting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == DECODE) begin
                op_cls  <= dec_cls;
                funct_q <= instr[2:0];
            end

            imem_req   <= (next_state == FETCH);
            dmem_req   <= (next_state == MEM);
            mem_read   <= (next_state == MEM) && (cls_eff == CLS_LW);
            mem_write  <= (next_state == MEM) && (cls_eff == CLS_SW);

            alu_src    <= (next_state == EXEC) && uses_immediate(cls_eff);
            alu_op     <= (next_state == EXEC) ? exec_alu_op : ALU_ADD;
            branch     <= (next_state == EXEC) && is_cond_branch(cls_eff);
            branch_ne  <= (next_state == EXEC) && (cls_eff == CLS_BNE);
            jump       <= (next_state == EXEC) && (cls_eff == CLS_J);

            reg_write  <= (next_state == WB);
            reg_dst    <= (next_state == WB) && (cls_eff == CLS_RTYPE);
            mem_to_reg <= (next_state == WB) && (cls_eff == CLS_LW);

            retire_q   <= (next_state == WB) ||
                          ((next_state == EXEC) && retires_in_exec(cls_eff));

            trap       <= (next_state == TRAP);
            if ((next_state == TRAP) && (state != TRAP)) begin
                trap_cause <= enter_cause;
            end
        end
    end

    // Ready- and zero-qualified outputs. Each is gated by a registered
    // request or select that is only high in the owning state, so a ready
    // arriving in any other state has no effect. The FETCH PC update takes
    // the PC+2 path because jump and branch are both low there.
    assign ir_write = imem_req & imem_ready;
    assign pc_write = ir_write | jump | (branch & (alu_zero ^ branch_ne));
    assign retire   = retire_q | (mem_write & dmem_ready);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each cycle the inputs are driven just
// after the rising edge and the full output bundle is sampled a few ns later
// and compared against a hand-built expected vector.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        alu_zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        ir_write;
    logic        pc_write;
    logic        jump;
    logic        branch;
    logic        reg_dst;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        retire;
    logic        trap;
    logic [1:0]  trap_cause;

    logic [18:0] outs;

    int vectors_applied = 0;
    int miscompares     = 0;
    int wait_n;
    logic wait_hit;

    // Output bundle bit positions, packed in port order.
    localparam logic [18:0] IMR    = 19'h40000;
    localparam logic [18:0] DMR    = 19'h20000;
    localparam logic [18:0] IRW    = 19'h10000;
    localparam logic [18:0] PCW    = 19'h08000;
    localparam logic [18:0] JMP    = 19'h04000;
    localparam logic [18:0] BRN    = 19'h02000;
    localparam logic [18:0] RDS    = 19'h01000;
    localparam logic [18:0] ASR    = 19'h00800;
    localparam logic [18:0] SUB    = 19'h00100;
    localparam logic [18:0] FN5    = 19'h00500;
    localparam logic [18:0] MRD    = 19'h00080;
    localparam logic [18:0] MWR    = 19'h00040;
    localparam logic [18:0] M2R    = 19'h00020;
    localparam logic [18:0] RGW    = 19'h00010;
    localparam logic [18:0] RET    = 19'h00008;
    localparam logic [18:0] TRP    = 19'h00004;
    localparam logic [18:0] C_ILL  = 19'h00001;
    localparam logic [18:0] C_IMEM = 19'h00002;
    localparam logic [18:0] C_DMEM = 19'h00003;
    localparam logic [18:0] FET    = IMR | IRW | PCW;
    localparam logic [18:0] NONE   = 19'h00000;

    assign outs = {imem_req, dmem_req, ir_write, pc_write, jump, branch,
                   reg_dst, alu_src, alu_op, mem_read, mem_write,
                   mem_to_reg, reg_write, retire, trap, trap_cause};

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .alu_zero   (alu_zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .jump       (jump),
        .branch     (branch),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and drive this cycle's inputs, leaving time for
    // the combinational outputs to settle before sampling.
    task automatic driveCycle(input logic [15:0] i, input logic ir,
                              input logic dr, input logic az);
        @(posedge clk);
        #1;
        instr      = i;
        imem_ready = ir;
        dmem_ready = dr;
        alu_zero   = az;
        #2;
    endtask

    // One directed vector: drive a cycle, then compare the output bundle.
    task automatic applyStimulus(input string tag, input logic [15:0] i,
                                 input logic ir, input logic dr, input logic az,
                                 input logic [18:0] expected);
        driveCycle(i, ir, dr, az);
        checkOutput(tag, 32'(outs), 32'(expected));
    endtask

    // Assert rst_n mid-cycle (outputs must drop immediately), then release
    // it; the idle FETCH cycle right after release must still be all zero.
    task automatic doReset(input string tag);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        instr      = 16'h0000;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_zero   = 1'b0;
        #2;
        checkOutput({tag, "_async"}, 32'(outs), 32'(NONE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        checkOutput({tag, "_idle"}, 32'(outs), 32'(NONE));
    endtask

    initial begin
        rst_n      = 1'b0;
        instr      = 16'h0000;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_zero   = 1'b0;

        doReset("reset");

        // ADD, no stalls: retire in cycle 4, single pc_write in FETCH.
        applyStimulus("add_fetch",  16'h2298, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("add_decode", 16'h2298, 1'b0, 1'b1, 1'b0, NONE);
        applyStimulus("add_exec",   16'h2298, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("add_wb",     16'h2298, 1'b0, 1'b0, 1'b0, RGW | RDS | RET);

        // R-type with funct 101 passes straight through to alu_op.
        applyStimulus("rt_fetch",  16'h2A9D, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("rt_decode", 16'h2A9D, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("rt_exec",   16'h2A9D, 1'b0, 1'b0, 1'b0, FN5);
        applyStimulus("rt_wb",     16'h2A9D, 1'b0, 1'b0, 1'b0, RGW | RDS | RET);

        // LW with dmem_ready low for 3 cycles: retire in cycle 8.
        applyStimulus("lw_fetch",  16'h0284, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("lw_decode", 16'h0284, 1'b1, 1'b0, 1'b0, NONE);
        applyStimulus("lw_exec",   16'h0284, 1'b0, 1'b0, 1'b0, ASR);
        applyStimulus("lw_mem1",   16'h0284, 1'b0, 1'b0, 1'b0, DMR | MRD);
        applyStimulus("lw_mem2",   16'h0284, 1'b0, 1'b0, 1'b0, DMR | MRD);
        applyStimulus("lw_mem3",   16'h0284, 1'b0, 1'b0, 1'b0, DMR | MRD);
        applyStimulus("lw_mem4",   16'h0284, 1'b0, 1'b1, 1'b0, DMR | MRD);
        applyStimulus("lw_wb",     16'h0284, 1'b0, 1'b0, 1'b0, RGW | M2R | RET);

        // BEQ taken and not taken, BNE both ways: retire in cycle 3.
        applyStimulus("beq_t_fetch",  16'hB000, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("beq_t_decode", 16'hB000, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("beq_t_exec",   16'hB000, 1'b0, 1'b0, 1'b1, BRN | PCW | RET | SUB);
        applyStimulus("beq_n_fetch",  16'hB000, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("beq_n_decode", 16'hB000, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("beq_n_exec",   16'hB000, 1'b0, 1'b0, 1'b0, BRN | RET | SUB);
        applyStimulus("bne_t_fetch",  16'hC000, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("bne_t_decode", 16'hC000, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("bne_t_exec",   16'hC000, 1'b0, 1'b0, 1'b0, BRN | PCW | RET | SUB);
        applyStimulus("bne_n_fetch",  16'hC000, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("bne_n_decode", 16'hC000, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("bne_n_exec",   16'hC000, 1'b0, 1'b0, 1'b1, BRN | RET | SUB);

        // Jump.
        applyStimulus("j_fetch",  16'hD000, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("j_decode", 16'hD000, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("j_exec",   16'hD000, 1'b0, 1'b0, 1'b0, JMP | PCW | RET);

        // ADDI: immediate add then writeback to instr[8:6].
        applyStimulus("addi_fetch",  16'h4283, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("addi_decode", 16'h4283, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("addi_exec",   16'h4283, 1'b0, 1'b0, 1'b0, ASR);
        applyStimulus("addi_wb",     16'h4283, 1'b0, 1'b0, 1'b0, RGW | RET);

        // SW retires in MEM on dmem_ready.
        applyStimulus("sw_fetch",  16'h1284, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("sw_decode", 16'h1284, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("sw_exec",   16'h1284, 1'b0, 1'b0, 1'b0, ASR);
        applyStimulus("sw_mem",    16'h1284, 1'b0, 1'b1, 1'b0, DMR | MWR | RET);

        // Fetch stall, then SW aborted by reset while waiting in MEM.
        applyStimulus("stall_fetch",    16'h1284, 1'b0, 1'b1, 1'b0, IMR);
        applyStimulus("swrst_fetch",    16'h1284, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("swrst_decode",   16'h1284, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("swrst_exec",     16'h1284, 1'b0, 1'b0, 1'b0, ASR);
        applyStimulus("swrst_mem",      16'h1284, 1'b0, 1'b0, 1'b0, DMR | MWR);
        doReset("swrst");

        // Illegal opcode 0111: sticky TRAP, ready ignored, reset recovers.
        applyStimulus("ill_fetch",  16'h7000, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("ill_decode", 16'h7000, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("ill_trap1",  16'h7000, 1'b1, 1'b1, 1'b0, TRP | C_ILL);
        applyStimulus("ill_trap2",  16'h7000, 1'b1, 1'b0, 1'b1, TRP | C_ILL);
        doReset("ill_rst");
        applyStimulus("ill_resume", 16'h0000, 1'b0, 1'b0, 1'b0, IMR);

        // HALT parks with everything low.
        applyStimulus("halt_fetch",  16'hF000, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("halt_decode", 16'hF000, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("halt_idle1",  16'hF000, 1'b1, 1'b1, 1'b0, NONE);
        applyStimulus("halt_idle2",  16'hF000, 1'b1, 1'b0, 1'b1, NONE);
        doReset("halt_rst");

        // imem_ready never arrives: trap with cause 10 after the wait limit.
        wait_n   = 0;
        wait_hit = 1'b0;
        for (int k = 0; k < 400 && !wait_hit; k++) begin
            driveCycle(16'h0000, 1'b0, 1'b0, 1'b0);
            if (trap) wait_hit = 1'b1;
            else if (imem_req) wait_n++;
        end
        checkOutput("imem_to_reached", 32'(wait_hit), 32'd1);
        checkOutput("imem_to_cycles", 32'((wait_n >= 255) && (wait_n <= 256)), 32'd1);
        checkOutput("imem_to_state", 32'(outs), 32'(TRP | C_IMEM));
        doReset("imem_to_rst");

        // dmem_ready never arrives on an LW: trap with cause 11.
        applyStimulus("dto_fetch",  16'h0284, 1'b1, 1'b0, 1'b0, FET);
        applyStimulus("dto_decode", 16'h0284, 1'b0, 1'b0, 1'b0, NONE);
        applyStimulus("dto_exec",   16'h0284, 1'b0, 1'b0, 1'b0, ASR);
        wait_n   = 0;
        wait_hit = 1'b0;
        for (int k = 0; k < 400 && !wait_hit; k++) begin
            driveCycle(16'h0284, 1'b0, 1'b0, 1'b0);
            if (trap) wait_hit = 1'b1;
            else if (dmem_req) wait_n++;
        end
        checkOutput("dmem_to_reached", 32'(wait_hit), 32'd1);
        checkOutput("dmem_to_cycles", 32'((wait_n >= 255) && (wait_n <= 256)), 32'd1);
        checkOutput("dmem_to_state", 32'(outs), 32'(TRP | C_DMEM));
        doReset("dmem_to_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the 16-bit RISC datapath.
- Sequences fetch/decode/execute/memory/writeback for each instruction and drives every datapath select line: reg_dst, alu_src, mem_to_reg, jump, branch.
- Handles instruction-memory and data-memory ready handshakes, with a wait timeout.
- Traps on illegal opcodes and on timeouts.

Parameters:
- TIMEOUT, 255: max cycles to wait for imem_ready/dmem_ready before trap.
- CNT_W, 8: width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  current IR contents; opcode is instr[15:12].
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction fetch complete.
- dmem_ready  in  1  data access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC from the pc_next mux.
- jump  out  1  pc_next select: jump target.
- branch  out  1  pc_2bne select: branch target.
- reg_dst  out  1  1 selects instr[5:3], 0 selects instr[8:6].
- alu_src  out  1  1 selects the extended immediate.
- alu_op  out  3  ALU function.
- mem_read  out  1  data read.
- mem_write  out  1  data write.
- mem_to_reg  out  1  writeback source is memory.
- reg_write  out  1  register file write enable.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  sticky error flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

Behaviour:
- Reset:
  - State goes to FETCH and the wait counter clears.
  - All outputs are 0, including trap_cause = 00.
  - imem_req asserts on the first clk edge after rst_n deasserts.
  - Reset mid-instruction aborts the instruction with no retire.
- Opcode encoding:
  - 0000 LW, 0001 SW, 0010 R-type (alu_op = instr[2:0]), 0100 ADDI.
  - 1011 BEQ, 1100 BNE, 1101 J, 1111 HALT.
  - All other opcodes are illegal.
- Outputs are Moore decodes of state and the latched opcode, plus ready/zero qualifiers noted below.
- FETCH:
  - imem_req = 1.
  - When imem_ready = 1: ir_write = 1, pc_write = 1 (PC+2; jump = 0, branch = 0), then go to DECODE.
  - Each cycle without ready increments the wait counter; counter = TIMEOUT goes to TRAP with cause 10.
- DECODE:
  - Opcode is latched.
  - Illegal opcode goes to TRAP with cause 01.
  - HALT goes to HALT.
  - All other opcodes go to EXEC.
- EXEC:
  - R-type: alu_src = 0, alu_op = funct.
  - LW, SW, ADDI: alu_src = 1, alu_op = 000 (add).
  - BEQ/BNE: alu_op = 001 (sub).
  - BEQ: pc_write = alu_zero, branch = 1.
  - BNE: pc_write = !alu_zero, branch = 1.
  - J: pc_write = 1, jump = 1.
  - Next state: BEQ/BNE/J retire and go to FETCH; LW/SW go to MEM; R-type and ADDI go to WB.
- MEM:
  - dmem_req = 1; LW drives mem_read = 1, SW drives mem_write = 1.
  - On dmem_ready: SW retires and goes to FETCH; LW goes to WB.
  - Timeout goes to TRAP with cause 11.
- WB:
  - reg_write = 1 for one cycle, then retire and go to FETCH.
  - R-type: reg_dst = 1.
  - ADDI/LW: reg_dst = 0.
  - LW: mem_to_reg = 1.
- Wait counter clears on every state change.
- Latency with ready asserted in the first wait cycle:
  - J/BEQ/BNE: 3 cycles.
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
- HALT and TRAP:
  - Both are terminal: all enables stay 0 and retire is 0.
  - trap stays high in TRAP.
  - Only rst_n exits either state.
- Ready asserted in a state that does not request it is ignored.

Decomposition:
- Package risc16_pkg holds:
  - opcode constants;
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP);
  - alu_op codes;
  - trap_cause codes.
- Sub-module opcode_decoder: combinational opcode to instruction class and legal flag.

Test Plan:
- ADD 0x2298 with imem_ready and no stalls: retire in cycle 4. WB cycle has reg_write = 1, reg_dst = 1, mem_to_reg = 0. Exactly one pc_write, in FETCH.
- LW 0x0284 with dmem_ready held low 3 cycles: MEM holds dmem_req = 1 and mem_read = 1 for 4 cycles. WB has mem_to_reg = 1, reg_dst = 0. retire in cycle 8.
- BEQ opcode 1011: with alu_zero = 1, the EXEC cycle has pc_write = 1 and branch = 1. With alu_zero = 0, pc_write = 0. retire in cycle 3 in both cases.
- Opcode 0111: TRAP, trap = 1, trap_cause = 01, no further imem_req. Then rst_n pulse: all outputs 0, FETCH resumes.
- imem_ready never asserted: after 255 wait cycles, trap_cause = 10.
- SW: rst_n asserted during MEM drops mem_write and dmem_req asynchronously with no retire.
